// File: rtl/ddr3_store_packer_if.sv
// DDR3 line-write channel between the store packer and the DDR3 controller.
// The packer drives the line write; the controller returns ready.
interface ddr3_store_packer_if;
  logic         ddr3_wr_valid_o;
  logic         ddr3_wr_ready_i;
  logic [31:0]  ddr3_wr_addr_o;
  logic [511:0] ddr3_wr_data_o;
  logic [63:0]  ddr3_wr_mask_o;

  modport master (
    output ddr3_wr_valid_o,
    output ddr3_wr_addr_o,
    output ddr3_wr_data_o,
    output ddr3_wr_mask_o,
    input  ddr3_wr_ready_i
  );

  modport slave (
    input  ddr3_wr_valid_o,
    input  ddr3_wr_addr_o,
    input  ddr3_wr_data_o,
    input  ddr3_wr_mask_o,
    output ddr3_wr_ready_i
  );
endinterface

// File: rtl/ddr3_store_packer.sv
// Coalesces one warp-wide store into masked 64-byte DDR3 line writes, one per
// distinct line, issued in ascending leader-lane order.
module ddr3_store_packer (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 store_valid_i,
  output logic                 store_ready_o,
  input  logic [1023:0]        StoreAddr_i,
  input  logic [1023:0]        StoreData_i,
  input  logic [31:0]          lane_mask_i,
  input  logic [1:0]           ldstWarp_i,
  ddr3_store_packer_if.master  wrPort,
  output logic                 storeDone_o,
  output logic [1:0]           storeDoneWarp_o
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} stateT;

  stateT        state, stateNext;
  logic         outEn;
  logic         accept;
  logic [31:0]  addrQ [32];
  logic [31:0]  dataQ [32];
  logic [31:0]  pending;
  logic [31:0]  groupQ;
  logic [1:0]   warpQ;
  logic [31:0]  wrAddrQ;
  logic [511:0] wrDataQ;
  logic [63:0]  wrMaskQ;

  logic [4:0]   leader;
  logic [25:0]  leadLine;
  logic [31:0]  groupC;
  logic [511:0] lineData;
  logic [63:0]  lineMask;
  logic [63:0]  unusedAddrLsbs;

  // outEn keeps store_ready_o low for the first cycle after reset releases.
  assign store_ready_o          = outEn && (state == IDLE) && !stall_i;
  assign wrPort.ddr3_wr_valid_o = (state == ISSUE);
  assign wrPort.ddr3_wr_addr_o  = wrAddrQ;
  assign wrPort.ddr3_wr_data_o  = wrDataQ;
  assign wrPort.ddr3_wr_mask_o  = wrMaskQ;
  assign storeDone_o            = (state == DONE);
  assign storeDoneWarp_o        = (state == DONE) ? warpQ : '0;

  // Ascending lane walk lets the higher lane overwrite a shared word.
  always_comb begin
    leader         = '0;
    groupC         = '0;
    lineData       = '0;
    lineMask       = '0;
    unusedAddrLsbs = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (pending[31 - i]) leader = 5'(31 - i);
    end
    leadLine = addrQ[leader][31:6];
    for (int unsigned i = 0; i < 32; i++) begin
      unusedAddrLsbs[2*i +: 2] = addrQ[i][1:0];
      if (pending[i] && (addrQ[i][31:6] == leadLine)) begin
        groupC[i] = 1'b1;
        lineData[{addrQ[i][5:2], 5'd0} +: 32] = dataQ[i];
        lineMask[{addrQ[i][5:2], 2'd0} +: 4]  = '1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (store_valid_i && store_ready_o) begin
          accept    = 1'b1;
          stateNext = (lane_mask_i != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (!stall_i) stateNext = ISSUE;
      end
      ISSUE: begin
        if (wrPort.ddr3_wr_ready_i)
          stateNext = ((pending & ~groupQ) != '0) ? SCAN : DONE;
      end
      DONE: begin
        if (!stall_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      outEn   <= 1'b0;
      pending <= '0;
      groupQ  <= '0;
      warpQ   <= '0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
      wrMaskQ <= '0;
    end else begin
      state <= stateNext;
      outEn <= 1'b1;
      if (accept) begin
        pending <= lane_mask_i;
        warpQ   <= ldstWarp_i;
      end
      if ((state == SCAN) && !stall_i) begin
        groupQ  <= groupC;
        wrAddrQ <= {leadLine, 6'd0};
        wrDataQ <= lineData;
        wrMaskQ <= lineMask;
      end
      if ((state == ISSUE) && wrPort.ddr3_wr_ready_i)
        pending <= pending & ~groupQ;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < 32; i++) begin
        addrQ[i] <= StoreAddr_i[32*i +: 32];
        dataQ[i] <= StoreData_i[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_store_packer.sv
// Directed bench for ddr3_store_packer: coalescing, multi-line order,
// backpressure, word collisions, empty masks and mid-operation reset.
module tb_ddr3_store_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          stall;
  logic          storeValid;
  logic          storeReady;
  logic [1023:0] storeAddr;
  logic [1023:0] storeData;
  logic [31:0]   laneMask;
  logic [1:0]    warp;
  logic          storeDone;
  logic [1:0]    storeDoneWarp;

  ddr3_store_packer_if wrBus ();

  ddr3_store_packer dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .store_valid_i   (storeValid),
    .store_ready_o   (storeReady),
    .StoreAddr_i     (storeAddr),
    .StoreData_i     (storeData),
    .lane_mask_i     (laneMask),
    .ldstWarp_i      (warp),
    .wrPort          (wrBus),
    .storeDone_o     (storeDone),
    .storeDoneWarp_o (storeDoneWarp)
  );

  int vectors     = 0;
  int miscompares = 0;
  int hsCount     = 0;
  int doneCycles  = 0;

  always @(posedge clk) begin
    if (wrBus.ddr3_wr_valid_o && wrBus.ddr3_wr_ready_i) hsCount++;
    if (storeDone) doneCycles++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int unsigned i, input logic [31:0] a, input logic [31:0] d);
    storeAddr[32*i +: 32] = a;
    storeData[32*i +: 32] = d;
  endtask

  task automatic clearLanes;
    for (int unsigned i = 0; i < 32; i++)
      setLane(i, 32'hF000_0000 + (i << 6), 32'hDEAD_0000 + i);
  endtask

  // Returns in the SCAN cycle following acceptance.
  task automatic sendReq(input logic [31:0] m, input logic [1:0] w);
    int unsigned waitCnt = 0;
    laneMask   = m;
    warp       = w;
    storeValid = 1'b1;
    while (!storeReady && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    vectors++;
    if (storeReady !== 1'b1) begin
      $display("FAIL accept_timeout: store_ready_o=%b required 1", storeReady);
      miscompares++;
    end
    tick();
    storeValid = 1'b0;
    laneMask   = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; storeValid = 1'b0; laneMask = '0; warp = '0;
    wrBus.ddr3_wr_ready_i = 1'b0;
    clearLanes();
    tick(); tick();
    vectors++;
    if ({storeReady, wrBus.ddr3_wr_valid_o, storeDone, storeDoneWarp} !== 5'b0) begin
      $display("FAIL reset_ctrl: ready/valid/done/warp=%b required 00000",
               {storeReady, wrBus.ddr3_wr_valid_o, storeDone, storeDoneWarp});
      miscompares++;
    end
    vectors++;
    if ({wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o} !== 96'h0 || wrBus.ddr3_wr_data_o !== 512'h0) begin
      $display("FAIL reset_bus: addr=%h mask=%h required 0", wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o);
      miscompares++;
    end
    reset = 1'b0;
    vectors++;
    if (storeReady !== 1'b0) begin
      $display("FAIL reset_release_ready: store_ready_o=%b required 0", storeReady);
      miscompares++;
    end
    tick();
    vectors++;
    if (storeReady !== 1'b1) begin
      $display("FAIL reset_ready_rise: store_ready_o=%b required 1", storeReady);
      miscompares++;
    end
  endtask

  task automatic test_coalesce;
    logic [31:0]  m = 32'h9003_8160;
    logic [511:0] expData = '0;
    int unsigned  j = 0;
    int           h0;
    clearLanes();
    for (int unsigned i = 0; i < 32; i++) begin
      if (m[i]) begin
        setLane(i, 32'h0022_CC40 + 4*j, 32'h1000 + j);
        expData[32*j +: 32] = 32'h1000 + j;
        j++;
      end
    end
    sendReq(m, 2'b10);
    vectors++;
    if (wrBus.ddr3_wr_valid_o !== 1'b0) begin
      $display("FAIL coalesce_scan_valid: valid=%b required 0", wrBus.ddr3_wr_valid_o);
      miscompares++;
    end
    tick();
    vectors++;
    if (wrBus.ddr3_wr_valid_o !== 1'b1 || wrBus.ddr3_wr_addr_o !== 32'h0022_CC40 ||
        wrBus.ddr3_wr_mask_o !== 64'h0000_0000_FFFF_FFFF) begin
      $display("FAIL coalesce_hdr: valid=%b addr=%h mask=%h required 1 0022cc40 00000000ffffffff",
               wrBus.ddr3_wr_valid_o, wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o);
      miscompares++;
    end
    vectors++;
    if (wrBus.ddr3_wr_data_o !== expData) begin
      $display("FAIL coalesce_data: got %h required %h", wrBus.ddr3_wr_data_o, expData);
      miscompares++;
    end
    h0 = hsCount;
    wrBus.ddr3_wr_ready_i = 1'b1;
    tick();
    wrBus.ddr3_wr_ready_i = 1'b0;
    vectors++;
    if (storeDone !== 1'b1 || storeDoneWarp !== 2'b10 || wrBus.ddr3_wr_valid_o !== 1'b0 || hsCount - h0 != 1) begin
      $display("FAIL coalesce_done: done=%b warp=%b valid=%b writes=%0d required 1 10 0 1",
               storeDone, storeDoneWarp, wrBus.ddr3_wr_valid_o, hsCount - h0);
      miscompares++;
    end
    tick();
    vectors++;
    if (storeDone !== 1'b0 || storeReady !== 1'b1) begin
      $display("FAIL coalesce_idle: done=%b ready=%b required 0 1", storeDone, storeReady);
      miscompares++;
    end
  endtask

  task automatic test_two_lines;
    logic [511:0] expData;
    logic [31:0]  expAddr;
    int           h0;
    clearLanes();
    for (int unsigned i = 0; i < 32; i++)
      setLane(i, (i < 16) ? 32'h1000 + 4*i : 32'h2000 + 4*(i - 16), 32'hA000_0000 + i);
    h0 = hsCount;
    sendReq(32'hFFFF_FFFF, 2'b01);
    tick();
    for (int unsigned ln = 0; ln < 2; ln++) begin
      expAddr = (ln == 0) ? 32'h1000 : 32'h2000;
      for (int unsigned w = 0; w < 16; w++) expData[32*w +: 32] = 32'hA000_0000 + 16*ln + w;
      vectors++;
      if (wrBus.ddr3_wr_valid_o !== 1'b1 || wrBus.ddr3_wr_addr_o !== expAddr || wrBus.ddr3_wr_mask_o !== '1) begin
        $display("FAIL two_lines_hdr%0d: valid=%b addr=%h mask=%h required 1 %h all-ones",
                 ln, wrBus.ddr3_wr_valid_o, wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o, expAddr);
        miscompares++;
      end
      vectors++;
      if (wrBus.ddr3_wr_data_o !== expData) begin
        $display("FAIL two_lines_data%0d: got %h required %h", ln, wrBus.ddr3_wr_data_o, expData);
        miscompares++;
      end
      wrBus.ddr3_wr_ready_i = 1'b1;
      tick();
      wrBus.ddr3_wr_ready_i = 1'b0;
      if (ln == 0) begin
        vectors++;
        if (wrBus.ddr3_wr_valid_o !== 1'b0 || storeDone !== 1'b0) begin
          $display("FAIL two_lines_gap: valid=%b done=%b required 0 0", wrBus.ddr3_wr_valid_o, storeDone);
          miscompares++;
        end
        tick();
      end
    end
    vectors++;
    if (storeDone !== 1'b1 || storeDoneWarp !== 2'b01 || hsCount - h0 != 2) begin
      $display("FAIL two_lines_done: done=%b warp=%b writes=%0d required 1 01 2",
               storeDone, storeDoneWarp, hsCount - h0);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_leader_order;
    logic [31:0]  expAddr [2];
    logic [63:0]  expMask [2];
    logic [511:0] expData [2];
    clearLanes();
    setLane(0, 32'h0200, 32'h11);
    setLane(1, 32'h0100, 32'h22);
    setLane(2, 32'h0206, 32'h33);
    expAddr[0] = 32'h0200; expMask[0] = 64'hFF; expData[0] = '0;
    expData[0][31:0] = 32'h11; expData[0][63:32] = 32'h33;
    expAddr[1] = 32'h0100; expMask[1] = 64'h0F; expData[1] = '0;
    expData[1][31:0] = 32'h22;
    sendReq(32'h7, 2'b00);
    tick();
    for (int unsigned ln = 0; ln < 2; ln++) begin
      vectors++;
      if (wrBus.ddr3_wr_valid_o !== 1'b1 || wrBus.ddr3_wr_addr_o !== expAddr[ln] ||
          wrBus.ddr3_wr_mask_o !== expMask[ln] || wrBus.ddr3_wr_data_o !== expData[ln]) begin
        $display("FAIL leader_order%0d: valid=%b addr=%h mask=%h data[63:0]=%h required 1 %h %h %h",
                 ln, wrBus.ddr3_wr_valid_o, wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o,
                 wrBus.ddr3_wr_data_o[63:0], expAddr[ln], expMask[ln], expData[ln][63:0]);
        miscompares++;
      end
      wrBus.ddr3_wr_ready_i = 1'b1;
      tick();
      wrBus.ddr3_wr_ready_i = 1'b0;
      if (ln == 0) tick();
    end
    vectors++;
    if (storeDone !== 1'b1) begin
      $display("FAIL leader_order_done: done=%b required 1", storeDone);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [511:0] expData = '0;
    int           h0;
    clearLanes();
    setLane(0, 32'h3004, 32'h5555_1234);
    expData[63:32] = 32'h5555_1234;
    h0 = hsCount;
    sendReq(32'h1, 2'b11);
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      vectors++;
      if (wrBus.ddr3_wr_valid_o !== 1'b1 || wrBus.ddr3_wr_addr_o !== 32'h3000 ||
          wrBus.ddr3_wr_mask_o !== 64'hF0 || wrBus.ddr3_wr_data_o !== expData) begin
        $display("FAIL backpressure_hold%0d: valid=%b addr=%h mask=%h required 1 00003000 f0",
                 c, wrBus.ddr3_wr_valid_o, wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o);
        miscompares++;
      end
      stall = ~stall;
      tick();
    end
    stall = 1'b0;
    wrBus.ddr3_wr_ready_i = 1'b1;
    tick();
    wrBus.ddr3_wr_ready_i = 1'b0;
    vectors++;
    if (storeDone !== 1'b1 || storeDoneWarp !== 2'b11 || hsCount - h0 != 1) begin
      $display("FAIL backpressure_done: done=%b warp=%b writes=%0d required 1 11 1",
               storeDone, storeDoneWarp, hsCount - h0);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_same_word;
    logic [511:0] expData = '0;
    clearLanes();
    setLane(3, 32'h4008, 32'hAAAA);
    setLane(9, 32'h4008, 32'hBBBB);
    expData[95:64] = 32'h0000_BBBB;
    sendReq(32'h0000_0208, 2'b00);
    tick();
    vectors++;
    if (wrBus.ddr3_wr_addr_o !== 32'h4000 || wrBus.ddr3_wr_mask_o !== 64'h0F00 ||
        wrBus.ddr3_wr_data_o !== expData) begin
      $display("FAIL same_word: addr=%h mask=%h word2=%h required 00004000 f00 0000bbbb",
               wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o, wrBus.ddr3_wr_data_o[95:64]);
      miscompares++;
    end
    wrBus.ddr3_wr_ready_i = 1'b1;
    tick();
    wrBus.ddr3_wr_ready_i = 1'b0;
    vectors++;
    if (storeDone !== 1'b1) begin
      $display("FAIL same_word_done: done=%b required 1", storeDone);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_empty_mask;
    int h0 = hsCount;
    int d0 = doneCycles;
    sendReq(32'h0, 2'b01);
    vectors++;
    if (storeDone !== 1'b1 || storeDoneWarp !== 2'b01 || wrBus.ddr3_wr_valid_o !== 1'b0) begin
      $display("FAIL empty_done: done=%b warp=%b valid=%b required 1 01 0",
               storeDone, storeDoneWarp, wrBus.ddr3_wr_valid_o);
      miscompares++;
    end
    tick();
    vectors++;
    if (storeDone !== 1'b0 || storeReady !== 1'b1) begin
      $display("FAIL empty_pulse_end: done=%b ready=%b required 0 1", storeDone, storeReady);
      miscompares++;
    end
    sendReq(32'h0, 2'b10);
    stall = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (storeDone !== 1'b1 || storeDoneWarp !== 2'b10 || storeReady !== 1'b0) begin
        $display("FAIL empty_stall_hold%0d: done=%b warp=%b ready=%b required 1 10 0",
                 c, storeDone, storeDoneWarp, storeReady);
        miscompares++;
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (storeDone !== 1'b0 || storeReady !== 1'b1 || hsCount != h0 || doneCycles - d0 != 4) begin
      $display("FAIL empty_release: done=%b ready=%b writes=%0d doneCycles=%0d required 0 1 0 4",
               storeDone, storeReady, hsCount - h0, doneCycles - d0);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    logic [511:0] expData = '0;
    int           d0;
    clearLanes();
    setLane(0, 32'h6000, 32'h99);
    sendReq(32'h1, 2'b01);
    tick();
    vectors++;
    if (wrBus.ddr3_wr_valid_o !== 1'b1) begin
      $display("FAIL reset_mid_issue: valid=%b required 1", wrBus.ddr3_wr_valid_o);
      miscompares++;
    end
    d0 = doneCycles;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({wrBus.ddr3_wr_valid_o, storeDone, storeDoneWarp, storeReady} !== 5'b0 ||
        {wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o} !== 96'h0 || wrBus.ddr3_wr_data_o !== 512'h0) begin
      $display("FAIL reset_mid_clear: valid=%b done=%b warp=%b ready=%b addr=%h mask=%h required all 0",
               wrBus.ddr3_wr_valid_o, storeDone, storeDoneWarp, storeReady,
               wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o);
      miscompares++;
    end
    tick(); tick();
    vectors++;
    if (doneCycles != d0 || storeReady !== 1'b1 || wrBus.ddr3_wr_valid_o !== 1'b0) begin
      $display("FAIL reset_mid_after: doneCycles=%0d ready=%b valid=%b required 0 1 0",
               doneCycles - d0, storeReady, wrBus.ddr3_wr_valid_o);
      miscompares++;
    end
    setLane(0, 32'h8004, 32'h77);
    expData[63:32] = 32'h77;
    sendReq(32'h1, 2'b10);
    tick();
    vectors++;
    if (wrBus.ddr3_wr_valid_o !== 1'b1 || wrBus.ddr3_wr_addr_o !== 32'h8000 ||
        wrBus.ddr3_wr_mask_o !== 64'hF0 || wrBus.ddr3_wr_data_o !== expData) begin
      $display("FAIL reset_mid_new: valid=%b addr=%h mask=%h required 1 00008000 f0",
               wrBus.ddr3_wr_valid_o, wrBus.ddr3_wr_addr_o, wrBus.ddr3_wr_mask_o);
      miscompares++;
    end
    wrBus.ddr3_wr_ready_i = 1'b1;
    tick();
    wrBus.ddr3_wr_ready_i = 1'b0;
    vectors++;
    if (storeDone !== 1'b1 || storeDoneWarp !== 2'b10) begin
      $display("FAIL reset_mid_done: done=%b warp=%b required 1 10", storeDone, storeDoneWarp);
      miscompares++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_coalesce();
    test_two_lines();
    test_leader_order();
    test_backpressure();
    test_same_word();
    test_empty_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
